// File: rtl/vga_capture.sv
// vga_capture: receive-side monitor for a VGA-style stream (hsync, vsync, rgb).
//
// Recovers visible pixel coordinates, checks line and frame periods against
// the timing parameters, and produces a per-frame checksum of visible pixels.
// All inputs are synchronous to clk (same pixel clock as the generator).
//
// Ports
//   clk         pixel clock
//   reset_n     asynchronous active-low reset
//   hsync       horizontal sync (active level = SYNC_POL)
//   vsync       vertical sync (active level = SYNC_POL)
//   rgb[2:0]    pixel colour
//   px_valid    px_x/px_y/px_rgb describe a visible pixel this cycle
//   px_x[9:0]   visible column
//   px_y[9:0]   visible row
//   px_rgb[2:0] registered colour of that pixel
//   frame_done  one-cycle pulse at each frame boundary, frame_sum valid with it
//   frame_sum   checksum of the frame just ended
//   locked      timing matches the parameters (state LOCKED)
//   line_err    sticky: bad line period seen while locked (or sync lost)
//   frame_err   sticky: bad frame line count seen while locked
//   state_dbg   current FSM state (0 HUNT, 1 SYNCING, 2 LOCKED)
//
// Output qualification: px_valid and frame_done are pure qualifiers with no
// back-pressure. A consumer must sample px_x/px_y/px_rgb only in cycles where
// px_valid is 1, and frame_sum only in the cycle where frame_done is 1.
// Neither output waits for, nor is held by, the consumer.

module vga_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 24,
    parameter int H_SYNC      = 40,
    parameter int H_BACK      = 128,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 9,
    parameter int V_SYNC      = 3,
    parameter int V_BACK      = 28,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [2:0]  px_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);

    localparam logic [11:0] H_TOTAL_C = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0]  V_LAST_C  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BACK + H_VISIBLE);
    // vsync asserts on the line before its first counted hsync, hence the -1.
    localparam logic [9:0]  V_START_C = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0]  V_END_C   = 10'(V_SYNC + V_BACK - 1 + V_VISIBLE);
    localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);
    localparam logic [10:0] H_MAX_C   = 11'h7FF;
    localparam logic [9:0]  L_MAX_C   = 10'h3FF;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNCING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  good_cnt, good_cnt_nx;
    logic        set_line_err, set_frame_err;

    // Input register stage; sync inputs are stored as "active" flags.
    logic        hs_a1, hs_a2, vs_a1, vs_a2;
    logic [2:0]  rgb_r;
    logic        h_edge, v_edge;

    logic [10:0] h_cnt, h_cnt_nx;
    logic [9:0]  line_cnt, line_cnt_nx;
    logic        seen_h;
    logic        line_bad;
    logic        line_mis, frame_mis, good_frame, h_sat;
    logic        h_vis, v_vis, pix_ok;
    logic [15:0] sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_a1 <= 1'b0;
            hs_a2 <= 1'b0;
            vs_a1 <= 1'b0;
            vs_a2 <= 1'b0;
            rgb_r <= 3'd0;
        end else begin
            hs_a1 <= (hsync == SYNC_POL);
            hs_a2 <= hs_a1;
            vs_a1 <= (vsync == SYNC_POL);
            vs_a2 <= vs_a1;
            rgb_r <= rgb;
        end
    end

    assign h_edge = hs_a1 & ~hs_a2;
    assign v_edge = vs_a1 & ~vs_a2;

    // The "_nx" counts belong to the sample currently held in rgb_r.
    always_comb begin
        h_cnt_nx = h_cnt;
        if (h_edge)
            h_cnt_nx = 11'd0;
        else if (h_cnt != H_MAX_C)
            h_cnt_nx = h_cnt + 11'd1;

        line_cnt_nx = line_cnt;
        if (v_edge)
            line_cnt_nx = 10'd0;
        else if (h_edge && (line_cnt != L_MAX_C))
            line_cnt_nx = line_cnt + 10'd1;
    end

    // h_cnt still holds the count of the last sample of the previous line.
    assign line_mis   = h_edge && seen_h && (({1'b0, h_cnt} + 12'd1) != H_TOTAL_C);
    assign frame_mis  = v_edge && (line_cnt != V_LAST_C);
    // A mismatch on the hsync that coincides with vsync belongs to the frame ending.
    assign good_frame = !frame_mis && !line_bad && !line_mis;
    assign h_sat      = (h_cnt == H_MAX_C) && !h_edge;

    assign h_vis  = (h_cnt_nx >= H_START_C) && (h_cnt_nx < H_END_C);
    assign v_vis  = (line_cnt_nx >= V_START_C) && (line_cnt_nx < V_END_C);
    assign pix_ok = h_vis && v_vis && (state != HUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt      <= 11'd0;
            line_cnt   <= 10'd0;
            seen_h     <= 1'b0;
            line_bad   <= 1'b0;
            px_valid   <= 1'b0;
            px_x       <= 10'd0;
            px_y       <= 10'd0;
            px_rgb     <= 3'd0;
            sum        <= 16'd0;
            frame_sum  <= 16'd0;
            frame_done <= 1'b0;
        end else begin
            h_cnt    <= h_cnt_nx;
            line_cnt <= line_cnt_nx;
            seen_h   <= seen_h | h_edge;
            line_bad <= v_edge ? 1'b0 : (line_bad | line_mis);

            px_valid <= pix_ok;
            if (pix_ok) begin
                px_x   <= 10'(h_cnt_nx - H_START_C);
                px_y   <= line_cnt_nx - V_START_C;
                px_rgb <= rgb_r;
            end

            frame_done <= v_edge;
            if (v_edge) begin
                frame_sum <= sum;
                sum       <= 16'd0;
            end else if (px_valid) begin
                sum <= {sum[14:0], sum[15]} ^ {13'd0, px_rgb};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            good_cnt  <= 8'd0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            good_cnt  <= good_cnt_nx;
            line_err  <= line_err | set_line_err;
            frame_err <= frame_err | set_frame_err;
        end
    end

    always_comb begin
        state_nx      = state;
        good_cnt_nx   = good_cnt;
        set_line_err  = 1'b0;
        set_frame_err = 1'b0;
        case (state)
            HUNT: begin
                if (v_edge) begin
                    state_nx    = SYNCING;
                    good_cnt_nx = 8'd0;
                end
            end
            SYNCING: begin
                if (v_edge) begin
                    if (!good_frame) begin
                        good_cnt_nx = 8'd0;
                    end else if ((good_cnt + 8'd1) >= LOCK_C) begin
                        state_nx    = LOCKED;
                        good_cnt_nx = 8'd0;
                    end else begin
                        good_cnt_nx = good_cnt + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_mis || frame_mis) begin
                    state_nx      = HUNT;
                    set_line_err  = line_mis;
                    set_frame_err = frame_mis;
                end
            end
            default: state_nx = HUNT;
        endcase
        // Sync lost entirely: h_cnt ran out without an hsync.
        if (h_sat) begin
            state_nx = HUNT;
            if (state == LOCKED)
                set_line_err = 1'b1;
        end
    end

    assign locked    = (state == LOCKED);
    assign state_dbg = state;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture with a reduced timing set so whole frames are short.
module tb_vga_capture;

    localparam int H_VISIBLE = 16;
    localparam int H_FRONT   = 6;
    localparam int H_SYNC    = 3;
    localparam int H_BACK    = 5;
    localparam int V_VISIBLE = 8;
    localparam int V_FRONT   = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 3;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 30
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 15
    localparam int H_START   = H_SYNC + H_BACK;                        // 8
    localparam int V_START   = V_SYNC + V_BACK - 1;                    // 4

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    logic        clk;
    logic        reset_n;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic        px_valid;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [2:0]  px_rgb;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic [1:0]  state_dbg;

    vga_capture #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .frame_done(frame_done), .frame_sum(frame_sum), .locked(locked),
        .line_err(line_err), .frame_err(frame_err), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [22:0] exp_q[$];     // {x, y, rgb} per expected visible pixel
    logic [31:0] exp_f_q[$];   // {pixel count, checksum} per expected frame_done
    int          n_vec;
    int          n_err;
    logic [15:0] model_sum;
    int          model_npx;
    int          px_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel or frame_done.
    initial begin
        px_seen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                px_seen = 0;
            end else begin
                if (px_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL px_unexpected: got x=%0d y=%0d rgb=%0d expected none",
                                 px_x, px_y, px_rgb);
                    end else begin
                        check("pixel", {9'd0, px_x, px_y, px_rgb}, {9'd0, exp_q.pop_front()});
                    end
                    px_seen++;
                end
                if (frame_done) begin
                    if (exp_f_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL frame_unexpected: got sum=%0h expected none", frame_sum);
                    end else begin
                        logic [31:0] e;
                        e = exp_f_q.pop_front();
                        check("frame_sum", {16'd0, frame_sum}, {16'd0, e[15:0]});
                        check("frame_px_count", px_seen, {16'd0, e[31:16]});
                    end
                    px_seen = 0;
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_sample(input logic hs, input logic vs, input logic [2:0] c);
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        rgb   = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_sample(1'b1, 1'b1, 3'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_px_valid"},   px_valid,   0);
        check({tag, "_px_x"},       px_x,       0);
        check({tag, "_px_y"},       px_y,       0);
        check({tag, "_px_rgb"},     px_rgb,     0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_sum"},  frame_sum,  0);
        check({tag, "_locked"},     locked,     0);
        check({tag, "_line_err"},   line_err,   0);
        check({tag, "_frame_err"},  frame_err,  0);
        check({tag, "_state"},      state_dbg,  S_HUNT);
    endtask

    // One frame starting with vsync and hsync asserting together on line 0.
    // long_line gets one extra pixel; at chk_line the state is checked on
    // both sides of the hsync edge; rst_line pulses reset_n in its front porch.
    task automatic drive_frame(input int nlines, input int pat, input bit px_on,
                               input int long_line, input int chk_line,
                               input bit lk_b, input bit lk_a, input logic [1:0] st_a,
                               input bit le_a, input bit fe_a, input int rst_line);
        bit live;
        exp_f_q.push_back({16'(model_npx), model_sum});
        model_sum = 16'd0;
        model_npx = 0;
        live = px_on;
        for (int l = 0; l < nlines; l++) begin
            int hlen;
            hlen = (l == long_line) ? H_TOTAL + 1 : H_TOTAL;
            for (int h = 0; h < hlen; h++) begin
                int x, y;
                bit vis;
                logic [2:0] c;
                x = h - H_START;
                y = l - V_START;
                vis = (x >= 0) && (x < H_VISIBLE) && (y >= 0) && (y < V_VISIBLE);
                if (!vis)          c = 3'd7;
                else if (pat == 0) c = 3'(x);
                else               c = 3'(x ^ (y * 3));
                drive_sample((h < H_SYNC) ? 1'b0 : 1'b1, (l < V_SYNC) ? 1'b0 : 1'b1, c);
                if (vis && live) begin
                    exp_q.push_back({10'(x), 10'(y), c});
                    model_sum = {model_sum[14:0], model_sum[15]} ^ {13'd0, c};
                    model_npx++;
                end
                if (l == chk_line && h == 1)
                    check("locked_before_edge", locked, lk_b);
                if (l == chk_line && h == 2) begin
                    check("locked_after_edge", locked, lk_a);
                    check("state_after_edge", state_dbg, st_a);
                    check("line_err_after_edge", line_err, le_a);
                    check("frame_err_after_edge", frame_err, fe_a);
                end
                if (l == rst_line && h == H_TOTAL - 4) begin
                    reset_n = 1'b0;
                    #1;
                    check_all_zero("midframe_reset");
                    check("px_queue_at_reset", exp_q.size(), 0);
                    exp_q.delete();
                    exp_f_q.delete();
                    live = 1'b0;
                    model_sum = 16'd0;
                    model_npx = 0;
                end
                if (l == rst_line && h == H_TOTAL - 1)
                    reset_n = 1'b1;
            end
        end
    endtask

    // Main sequence
    initial begin
        n_vec = 0;
        n_err = 0;
        model_sum = 16'd0;
        model_npx = 0;
        reset_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        reset_n = 1'b1;
        idle(4);

        // Lock on ideal stream: locked rises at the 3rd vsync edge.
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 0, S_SYNC, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        check("locked_before_3rd_edge", locked, 0);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 1, S_LOCK, 0, 0, -1);
        drive_frame(V_TOTAL, 1, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);

        // One 31-clock line while locked.
        drive_frame(V_TOTAL, 0, 0, 1, 2, 1, 0, S_HUNT, 1, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 0, S_SYNC, 1, 0, -1);
        drive_frame(V_TOTAL, 1, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 1, S_LOCK, 1, 0, -1);

        // Reset pulse in the middle of a locked frame, then relock.
        drive_frame(V_TOTAL, 1, 1, -1, -1, 0, 0, S_HUNT, 0, 0, 7);
        check("reset_then_hunt", state_dbg, S_HUNT);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 0, S_SYNC, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 1, S_LOCK, 0, 0, -1);

        // One frame of V_TOTAL+1 lines while locked.
        drive_frame(V_TOTAL + 1, 1, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 0, -1, 0, 1, 0, S_HUNT, 0, 1, -1);
        drive_frame(V_TOTAL, 0, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 1, 1, -1, 0, 0, 1, S_LOCK, 0, 1, -1);

        // hsync held inactive long enough for h_cnt to saturate.
        check("line_err_before_hold", line_err, 0);
        idle(2100);
        check("hold_locked", locked, 0);
        check("hold_state", state_dbg, S_HUNT);
        check("hold_line_err", line_err, 1);
        check("hold_frame_err", frame_err, 1);
        check("hold_px_valid", px_valid, 0);

        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 0, S_SYNC, 1, 1, -1);
        drive_frame(V_TOTAL, 1, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        drive_frame(V_TOTAL, 0, 1, -1, 0, 0, 1, S_LOCK, 1, 1, -1);
        // A final vsync edge so the last full frame reports its checksum.
        drive_frame(1, 0, 1, -1, -1, 0, 0, S_HUNT, 0, 0, -1);
        idle(20);

        check("px_queue_empty", exp_q.size(), 0);
        check("frame_queue_empty", exp_f_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
